// File: rtl/pingpong_buffer_ctrl.sv
// pingpong_buffer_ctrl
// Double-buffer sequencer: the producer fills the back RAM while the reader
// drains the front RAM. The two swap at a frame boundary only when the back
// RAM holds a complete frame. Otherwise the stale frame is repeated and a
// miss is counted.
module pingpong_buffer_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          frame_start,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          ram0_wren,
    output logic          ram1_wren,
    output logic          ram0_rden,
    output logic          ram1_rden,
    output logic [AW-1:0] ram0_addr,
    output logic [AW-1:0] ram1_addr,
    output logic [DW-1:0] ram0_wdata,
    output logic [DW-1:0] ram1_wdata,
    input  logic [DW-1:0] ram0_q,
    input  logic [DW-1:0] ram1_q,
    output logic          front_sel,
    output logic          front_valid,
    output logic          swapped,
    output logic [7:0]    miss_cnt
);

    typedef enum logic {
        FILL  = 1'b0,
        READY = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t          state_q, state_d;
    logic [AW-1:0]   wrAddr_q, wrAddr_d;
    logic            frontSel_q, frontSel_d;
    logic            frontValid_q, frontValid_d;
    logic            swapped_q, swapped_d;
    logic [7:0]      missCnt_q, missCnt_d;

    logic            rdReq1_q;
    logic            rdSel1_q;
    logic            rdFrontValid1_q;
    logic            rdValid_q;
    logic [DW-1:0]   rdData_q;

    logic            wrAccept;
    logic            lastWrite;
    logic            rdEn;

    // Handshake and RAM role steering; the back RAM is always !frontSel_q,
    // so the write and read roles can never land on the same RAM.
    assign wr_ready   = (state_q == FILL);
    assign wrAccept   = wr_ready && wr_valid && !reset;
    assign lastWrite  = wrAccept && (wrAddr_q == LAST_ADDR);
    assign rdEn       = rd_req && !reset;

    assign ram0_wren  = wrAccept && frontSel_q;
    assign ram1_wren  = wrAccept && !frontSel_q;
    assign ram0_rden  = rdEn && !frontSel_q;
    assign ram1_rden  = rdEn && frontSel_q;
    assign ram0_addr  = frontSel_q ? wrAddr_q : rd_addr;
    assign ram1_addr  = frontSel_q ? rd_addr : wrAddr_q;
    assign ram0_wdata = wr_data;
    assign ram1_wdata = wr_data;

    assign front_sel   = frontSel_q;
    assign front_valid = frontValid_q;
    assign swapped     = swapped_q;
    assign miss_cnt    = missCnt_q;
    assign rd_valid    = rdValid_q;
    assign rd_data     = rdData_q;

    // Next-state for the fill/swap sequencer; a swap overrides the fill
    // bookkeeping, including the case where the last write and the frame
    // boundary coincide.
    always_comb begin
        state_d      = state_q;
        wrAddr_d     = wrAddr_q;
        frontSel_d   = frontSel_q;
        frontValid_d = frontValid_q;
        swapped_d    = 1'b0;
        missCnt_d    = missCnt_q;
        if (wrAccept) begin
            if (lastWrite) begin
                state_d  = READY;
                wrAddr_d = '0;
            end else begin
                wrAddr_d = wrAddr_q + AW'(1);
            end
        end
        if (frame_start) begin
            if ((state_q == READY) || lastWrite) begin
                frontSel_d   = !frontSel_q;
                frontValid_d = 1'b1;
                swapped_d    = 1'b1;
                state_d      = FILL;
                wrAddr_d     = '0;
            end else if (missCnt_q != 8'hFF) begin
                missCnt_d = missCnt_q + 8'd1;
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FILL;
            wrAddr_q     <= '0;
            frontSel_q   <= 1'b0;
            frontValid_q <= 1'b0;
            swapped_q    <= 1'b0;
            missCnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            wrAddr_q     <= wrAddr_d;
            frontSel_q   <= frontSel_d;
            frontValid_q <= frontValid_d;
            swapped_q    <= swapped_d;
            missCnt_q    <= missCnt_d;
        end
    end

    // Two-stage read pipeline; stage 1 remembers which RAM the request went
    // to so a read straddling a swap returns data from the RAM it addressed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdReq1_q        <= 1'b0;
            rdSel1_q        <= 1'b0;
            rdFrontValid1_q <= 1'b0;
            rdValid_q       <= 1'b0;
            rdData_q        <= '0;
        end else begin
            rdReq1_q        <= rdEn;
            rdSel1_q        <= frontSel_q;
            rdFrontValid1_q <= frontValid_q;
            rdValid_q       <= rdReq1_q;
            if (rdReq1_q) begin
                if (!rdFrontValid1_q) begin
                    rdData_q <= '0;
                end else begin
                    rdData_q <= rdSel1_q ? ram1_q : ram0_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_pingpong_buffer_ctrl.sv
// Testbench for pingpong_buffer_ctrl: two behavioural RAMs, directed
// stimulus, and a read scoreboard drained by an independent monitor.
module tb_pingpong_buffer_ctrl;

    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_start;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          ram0_wren, ram1_wren, ram0_rden, ram1_rden;
    logic [AW-1:0] ram0_addr, ram1_addr;
    logic [DW-1:0] ram0_wdata, ram1_wdata;
    logic [DW-1:0] ram0_q, ram1_q;
    logic          front_sel, front_valid, swapped;
    logic [7:0]    miss_cnt;

    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];

    logic [DW-1:0] expQ [$];
    int            checks   = 0;
    int            failures = 0;

    pingpong_buffer_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .ram0_wren(ram0_wren), .ram1_wren(ram1_wren),
        .ram0_rden(ram0_rden), .ram1_rden(ram1_rden),
        .ram0_addr(ram0_addr), .ram1_addr(ram1_addr),
        .ram0_wdata(ram0_wdata), .ram1_wdata(ram1_wdata),
        .ram0_q(ram0_q), .ram1_q(ram1_q),
        .front_sel(front_sel), .front_valid(front_valid),
        .swapped(swapped), .miss_cnt(miss_cnt)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Single-port synchronous RAM models with one-cycle read latency.
    always @(posedge clk) begin
        if (ram0_wren) mem0[ram0_addr] <= ram0_wdata;
        if (ram0_rden) ram0_q <= mem0[ram0_addr];
        if (ram1_wren) mem1[ram1_addr] <= ram1_wdata;
        if (ram1_rden) ram1_q <= mem1[ram1_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs just after the edge, queue the expected read
    // data, then park on the following negedge for sampling.
    task automatic applyStimulus(input logic fs, input logic wv, input logic [DW-1:0] wd,
                                 input logic rr, input logic [AW-1:0] ra, input logic [DW-1:0] rexp);
        @(posedge clk);
        #1;
        frame_start = fs;
        wr_valid    = wv;
        wr_data     = wd;
        rd_req      = rr;
        rd_addr     = ra;
        if (rr) expQ.push_back(rexp);
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 20 && expQ.size() != 0; i++) @(negedge clk);
        checkOutput("rd_drain_pending", 32'(expQ.size()), 32'd0);
        expQ.delete();
    endtask

    // Monitor: every presented read result is checked against the queue.
    always @(negedge clk) begin
        if (rd_valid) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL rd_unexpected actual=0x%0h required=no_read at %0t", rd_data, $time);
            end else begin
                logic [DW-1:0] e;
                e = expQ.pop_front();
                checkOutput("rd_data", 32'(rd_data), 32'(e));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DW-1:0] fillData [4];
        fillData[0] = 8'h11; fillData[1] = 8'h22; fillData[2] = 8'h33; fillData[3] = 8'h44;
        for (int i = 0; i < DEPTH; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        ram0_q = '0;
        ram1_q = '0;

        // Reset held with requests active: no enable may fire.
        reset = 1'b1; frame_start = 1'b0; wr_valid = 1'b1; wr_data = 8'h5A;
        rd_req = 1'b1; rd_addr = 2'd1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_enables", 32'({ram0_wren, ram1_wren, ram0_rden, ram1_rden}), 32'd0);
        end
        checkOutput("rst_front_sel", 32'(front_sel), 32'd0);
        checkOutput("rst_front_valid", 32'(front_valid), 32'd0);
        checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
        checkOutput("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        checkOutput("rst_swapped", 32'(swapped), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0; wr_valid = 1'b0; rd_req = 1'b0;

        // Idle: no enables, outputs stay at reset values.
        for (int i = 0; i < 10; i++) begin
            idle();
            checkOutput("idle_enables", 32'({ram0_wren, ram1_wren, ram0_rden, ram1_rden}), 32'd0);
        end
        checkOutput("idle_wr_ready", 32'(wr_ready), 32'd1);
        checkOutput("idle_swapped", 32'(swapped), 32'd0);

        // Read before any frame is valid returns zero.
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 8'h00);
        idle();
        waitDrain();

        // Full fill into ram1, then swap.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, fillData[i], 1'b0, 2'd0, 8'h00);
            checkOutput("fill_ram1_wren", 32'({ram1_wren, ram0_wren}), 32'b10);
            checkOutput("fill_ram1_addr", 32'(ram1_addr), 32'(i));
        end
        idle();
        checkOutput("ready_wr_ready", 32'(wr_ready), 32'd0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 8'h00);
        checkOutput("pre_swap_front_sel", 32'(front_sel), 32'd0);
        idle();
        checkOutput("swap1_pulse", 32'(swapped), 32'd1);
        checkOutput("swap1_front_sel", 32'(front_sel), 32'd1);
        checkOutput("swap1_front_valid", 32'(front_valid), 32'd1);
        checkOutput("swap1_wr_ready", 32'(wr_ready), 32'd1);
        idle();
        checkOutput("swap1_pulse_end", 32'(swapped), 32'd0);

        // Back-to-back reads of the new front (ram1).
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 2'(i), fillData[i]);
            checkOutput("rd_ram1_rden", 32'({ram1_rden, ram0_rden}), 32'b10);
        end
        idle();
        waitDrain();

        // Late fill into ram0: a miss, then completion and swap.
        applyStimulus(1'b0, 1'b1, 8'hA1, 1'b0, 2'd0, 8'h00);
        checkOutput("late_ram0_wren", 32'({ram0_wren, ram1_wren}), 32'b10);
        applyStimulus(1'b0, 1'b1, 8'hA2, 1'b0, 2'd0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 8'h00);
        idle();
        checkOutput("late_miss_cnt", 32'(miss_cnt), 32'd1);
        checkOutput("late_no_swap", 32'(swapped), 32'd0);
        checkOutput("late_front_sel", 32'(front_sel), 32'd1);
        applyStimulus(1'b0, 1'b1, 8'hA3, 1'b0, 2'd0, 8'h00);
        checkOutput("late_ram0_addr2", 32'(ram0_addr), 32'd2);
        applyStimulus(1'b0, 1'b1, 8'hA4, 1'b0, 2'd0, 8'h00);
        checkOutput("late_ram0_addr3", 32'(ram0_addr), 32'd3);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 8'h00);
        idle();
        checkOutput("late_swap_pulse", 32'(swapped), 32'd1);
        checkOutput("late_swap_front_sel", 32'(front_sel), 32'd0);
        checkOutput("late_swap_miss_cnt", 32'(miss_cnt), 32'd1);

        // Final write coincides with frame_start.
        applyStimulus(1'b0, 1'b1, 8'hB1, 1'b0, 2'd0, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'hB2, 1'b0, 2'd0, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'hB3, 1'b0, 2'd0, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'hB4, 1'b0, 2'd0, 8'h00);
        checkOutput("simul_ram1_addr", 32'(ram1_addr), 32'd3);
        applyStimulus(1'b0, 1'b1, 8'hC1, 1'b0, 2'd0, 8'h00);
        checkOutput("simul_swap_pulse", 32'(swapped), 32'd1);
        checkOutput("simul_front_sel", 32'(front_sel), 32'd1);
        checkOutput("simul_miss_cnt", 32'(miss_cnt), 32'd1);
        checkOutput("simul_next_wr", 32'({ram0_wren, ram1_wren, 2'(ram0_addr)}), 32'b1000);
        applyStimulus(1'b0, 1'b1, 8'hC2, 1'b0, 2'd0, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'hC3, 1'b0, 2'd0, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'hC4, 1'b0, 2'd0, 8'h00);

        // Reads straddling a swap: before, on, and after the swap edge.
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 2'd2, 8'hB3);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 2'd2, 8'hB3);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 2'd2, 8'hC3);
        checkOutput("xswap_front_sel", 32'(front_sel), 32'd0);
        idle();
        waitDrain();

        // Reset in the middle of a fill into ram1.
        applyStimulus(1'b0, 1'b1, 8'hD1, 1'b0, 2'd0, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'hD2, 1'b0, 2'd0, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'hD3, 1'b0, 2'd0, 8'h00);
        @(posedge clk);
        #1;
        reset = 1'b1; wr_valid = 1'b0;
        @(negedge clk);
        checkOutput("midrst_front_valid", 32'(front_valid), 32'd0);
        checkOutput("midrst_front_sel", 32'(front_sel), 32'd0);
        checkOutput("midrst_miss_cnt", 32'(miss_cnt), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midrst_wr_ready", 32'(wr_ready), 32'd1);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 8'h00);
        idle();
        checkOutput("midrst_no_swap", 32'(swapped), 32'd0);
        checkOutput("midrst_miss1", 32'(miss_cnt), 32'd1);
        applyStimulus(1'b0, 1'b1, 8'hE1, 1'b0, 2'd0, 8'h00);
        checkOutput("midrst_wr_addr0", 32'({ram1_wren, 2'(ram1_addr)}), 32'b100);
        applyStimulus(1'b0, 1'b1, 8'hE2, 1'b0, 2'd0, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'hE3, 1'b0, 2'd0, 8'h00);
        checkOutput("midrst_pre_swap", 32'(front_valid), 32'd0);
        applyStimulus(1'b0, 1'b1, 8'hE4, 1'b0, 2'd0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 8'h00);
        idle();
        checkOutput("midrst_swap_sel", 32'(front_sel), 32'd1);
        checkOutput("midrst_swap_valid", 32'(front_valid), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 8'hE1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 2'd3, 8'hE4);
        idle();
        waitDrain();

        // Miss counter saturation with 300 frame boundaries and no writes.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 8'h00);
            idle();
        end
        checkOutput("sat_miss_cnt", 32'(miss_cnt), 32'd255);
        checkOutput("sat_front_sel", 32'(front_sel), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
